// File: rtl/iob_ethoc_arb_pkg.sv
// Shared definitions for the iob_ethoc two-requester arbiter:
// FSM state encoding, the data returned on a watchdog abort, and a small
// helper that turns a requester index into a one-hot grant vector.
package iob_ethoc_arb_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Read data handed back when the watchdog aborts a transaction
    localparam logic [31:0] ETHOC_ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Requester index (0 = CPU, 1 = DMA engine) to one-hot grant
    function automatic logic [1:0] arb_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/iob_ethoc_arb_rr.sv
// Combinational round-robin selector for two requesters.
// A lone requester always wins; on a tie the requester that did not win
// last time is chosen. Output is the one-hot winner, 00 when nobody asks.
module iob_ethoc_arb_rr
    import iob_ethoc_arb_pkg::*;
(
    input  logic       i_m0_valid,
    input  logic       i_m1_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_winner
);

    // Pick the winner from the current valids and the last grant
    always_comb begin
        o_winner = 2'b00;
        if (i_m0_valid && i_m1_valid) begin
            o_winner = arb_onehot(~i_last_grant);
        end else if (i_m0_valid) begin
            o_winner = 2'b01;
        end else if (i_m1_valid) begin
            o_winner = 2'b10;
        end
    end

endmodule

// File: rtl/iob_ethoc_arbiter.sv
// Two-requester IOb arbiter in front of the iob_ethoc register/descriptor
// slave port. Requester 0 is the CPU, requester 1 the descriptor/DMA engine.
// One transaction at a time: IDLE picks a winner and registers its request,
// REQ holds it on the slave port until acknowledged, RESP returns a one-cycle
// ready pulse to the winner only.
// Optional feature macro: ETHOC_ARB_TIMEOUT_EN adds a watchdog that aborts a
// transaction after TIMEOUT_CYC cycles in REQ without acknowledge.
module iob_ethoc_arbiter
    import iob_ethoc_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                arst_i,

    input  logic                m0_valid_i,
    input  logic [ADDR_W-1:0]   m0_address_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_ready_o,

    input  logic                m1_valid_i,
    input  logic [ADDR_W-1:0]   m1_address_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_ready_o,

    output logic                s_valid_o,
    output logic [ADDR_W-1:0]   s_address_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_ready_i,

    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    localparam int STRB_W = DATA_W / 8;

    // State and registered outputs
    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                r_s_valid,   w_s_valid_next;
    logic [ADDR_W-1:0]   r_s_address, w_s_address_next;
    logic [DATA_W-1:0]   r_s_wdata,   w_s_wdata_next;
    logic [STRB_W-1:0]   r_s_wstrb,   w_s_wstrb_next;
    logic [DATA_W-1:0]   r_rdata,     w_rdata_next;
    logic                r_m0_ready,  w_m0_ready_next;
    logic                r_m1_ready,  w_m1_ready_next;
    logic [1:0]          r_grant,     w_grant_next;
    logic                r_last_grant, w_last_grant_next;

    // Winner selection and the winner's request payload
    logic [1:0]          w_winner;
    logic [ADDR_W-1:0]   w_sel_address;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [STRB_W-1:0]   w_sel_wstrb;

`ifdef ETHOC_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0]    r_cnt,     w_cnt_next;
    logic                r_timeout, w_timeout_next;
    logic                w_expire;

    // Watchdog limit reached on this REQ cycle
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Watchdog absent: the limit parameter has no effect in this build
    logic                w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

    iob_ethoc_arb_rr u_rr (
        .i_m0_valid   (m0_valid_i),
        .i_m1_valid   (m1_valid_i),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    // Requester 1 payload when it wins, otherwise requester 0
    assign w_sel_address = w_winner[1] ? m1_address_i : m0_address_i;
    assign w_sel_wdata   = w_winner[1] ? m1_wdata_i   : m0_wdata_i;
    assign w_sel_wstrb   = w_winner[1] ? m1_wstrb_i   : m0_wstrb_i;

    // Next-state and next-register logic for the transaction FSM
    always_comb begin
        w_state_next      = r_state;
        w_s_valid_next    = r_s_valid;
        w_s_address_next  = r_s_address;
        w_s_wdata_next    = r_s_wdata;
        w_s_wstrb_next    = r_s_wstrb;
        w_rdata_next      = r_rdata;
        w_m0_ready_next   = 1'b0;
        w_m1_ready_next   = 1'b0;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
`ifdef ETHOC_ARB_TIMEOUT_EN
        w_cnt_next        = r_cnt;
        w_timeout_next    = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (|w_winner) begin
                    w_state_next      = REQ;
                    w_s_valid_next    = 1'b1;
                    w_s_address_next  = w_sel_address;
                    w_s_wdata_next    = w_sel_wdata;
                    w_s_wstrb_next    = w_sel_wstrb;
                    w_grant_next      = w_winner;
                    w_last_grant_next = w_winner[1];
`ifdef ETHOC_ARB_TIMEOUT_EN
                    w_cnt_next        = '0;
`endif
                end
            end

            REQ: begin
                // An acknowledge on the expiry cycle still counts as normal completion
                if (s_ready_i) begin
                    w_state_next    = RESP;
                    w_s_valid_next  = 1'b0;
                    w_rdata_next    = s_rdata_i;
                    w_m0_ready_next = r_grant[0];
                    w_m1_ready_next = r_grant[1];
                end
`ifdef ETHOC_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_next    = RESP;
                    w_s_valid_next  = 1'b0;
                    w_rdata_next    = DATA_W'(ETHOC_ARB_TIMEOUT_RDATA);
                    w_m0_ready_next = r_grant[0];
                    w_m1_ready_next = r_grant[1];
                    w_timeout_next  = 1'b1;
                end else begin
                    w_cnt_next      = r_cnt + 1'b1;
                end
`endif
            end

            RESP: begin
                // Ready pulse is on the outputs this cycle; release the bus
                w_state_next = IDLE;
                w_grant_next = 2'b00;
            end

            default: begin
                w_state_next   = IDLE;
                w_s_valid_next = 1'b0;
                w_grant_next   = 2'b00;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Forwarded request, response and grant registers
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_s_valid    <= 1'b0;
            r_s_address  <= '0;
            r_s_wdata    <= '0;
            r_s_wstrb    <= '0;
            r_rdata      <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
        end else begin
            r_s_valid    <= w_s_valid_next;
            r_s_address  <= w_s_address_next;
            r_s_wdata    <= w_s_wdata_next;
            r_s_wstrb    <= w_s_wstrb_next;
            r_rdata      <= w_rdata_next;
            r_m0_ready   <= w_m0_ready_next;
            r_m1_ready   <= w_m1_ready_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

`ifdef ETHOC_ARB_TIMEOUT_EN
    // Watchdog counter and abort pulse
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign s_valid_o   = r_s_valid;
    assign s_address_o = r_s_address;
    assign s_wdata_o   = r_s_wdata;
    assign s_wstrb_o   = r_s_wstrb;
    assign m0_rdata_o  = r_rdata;
    assign m1_rdata_o  = r_rdata;
    assign m0_ready_o  = r_m0_ready;
    assign m1_ready_o  = r_m1_ready;
    assign grant_o     = r_grant;

endmodule

// File: tb/tb_iob_ethoc_arbiter.sv
// Directed self-checking bench for iob_ethoc_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with ETHOC_ARB_TIMEOUT_EN defined to exercise the watchdog abort.
module tb_iob_ethoc_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b0;
    logic          m0_valid_i = 1'b0, m1_valid_i = 1'b0;
    logic [AW-1:0] m0_address_i = '0, m1_address_i = '0;
    logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic [SW-1:0] m0_wstrb_i = '0, m1_wstrb_i = '0;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          m0_ready_o, m1_ready_o;
    logic          s_valid_o;
    logic [AW-1:0] s_address_o;
    logic [DW-1:0] s_wdata_o;
    logic [SW-1:0] s_wstrb_o;
    logic [DW-1:0] s_rdata_i = '0;
    logic          s_ready_i = 1'b0;
    logic [1:0]    grant_o;
    logic          timeout_o;

    int n_total = 0;
    int n_bad   = 0;

    iob_ethoc_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .m0_valid_i   (m0_valid_i),
        .m0_address_i (m0_address_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_wstrb_i   (m0_wstrb_i),
        .m0_rdata_o   (m0_rdata_o),
        .m0_ready_o   (m0_ready_o),
        .m1_valid_i   (m1_valid_i),
        .m1_address_i (m1_address_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_wstrb_i   (m1_wstrb_i),
        .m1_rdata_o   (m1_rdata_o),
        .m1_ready_o   (m1_ready_o),
        .s_valid_o    (s_valid_o),
        .s_address_o  (s_address_o),
        .s_wdata_o    (s_wdata_o),
        .s_wstrb_o    (s_wstrb_o),
        .s_rdata_i    (s_rdata_i),
        .s_ready_i    (s_ready_i),
        .grant_o      (grant_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Step falling edges until s_valid_o is seen, bounded
    task automatic wait_svalid(input string tag);
        int k;
        k = 0;
        while (s_valid_o !== 1'b1 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        check_eq(tag, 64'(s_valid_o), 64'd1);
    endtask

    // Acknowledge for one cycle; returns on the RESP-cycle falling edge
    task automatic slave_ack(input logic [DW-1:0] d);
        s_ready_i = 1'b1;
        s_rdata_i = d;
        @(negedge clk_i);
        s_ready_i = 1'b0;
        s_rdata_i = '0;
    endtask

    task automatic do_reset();
        arst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] exp_g;
        int         k;
        int         n_sv;

        // Reset state
        #3;
        check_eq("rst_svalid", 64'(s_valid_o), 64'd0);
        check_eq("rst_grant", 64'(grant_o), 64'd0);
        check_eq("rst_saddr", 64'(s_address_o), 64'd0);
        check_eq("rst_rdata", 64'(m0_rdata_o), 64'd0);
        check_eq("rst_ready", 64'({m0_ready_o, m1_ready_o}), 64'd0);
        check_eq("rst_timeout", 64'(timeout_o), 64'd0);
        @(negedge clk_i);
        arst_i = 1'b1;

        // Single read by m0, acknowledged on cycle 3
        m0_valid_i = 1'b1; m0_address_i = 16'h0010; m0_wstrb_i = '0;
        @(negedge clk_i);
        check_eq("rd_c1_svalid", 64'(s_valid_o), 64'd1);
        check_eq("rd_c1_grant", 64'(grant_o), 64'd1);
        check_eq("rd_c1_saddr", 64'(s_address_o), 64'h0010);
        check_eq("rd_c1_swstrb", 64'(s_wstrb_o), 64'd0);
        @(negedge clk_i);
        check_eq("rd_c2_svalid", 64'(s_valid_o), 64'd1);
        @(negedge clk_i);
        check_eq("rd_c3_svalid", 64'(s_valid_o), 64'd1);
        check_eq("rd_c3_ready", 64'(m0_ready_o), 64'd0);
        slave_ack(32'h1234_5678);
        check_eq("rd_c4_m0ready", 64'(m0_ready_o), 64'd1);
        check_eq("rd_c4_m1ready", 64'(m1_ready_o), 64'd0);
        check_eq("rd_c4_m0rdata", 64'(m0_rdata_o), 64'h1234_5678);
        check_eq("rd_c4_m1rdata", 64'(m1_rdata_o), 64'h1234_5678);
        check_eq("rd_c4_svalid", 64'(s_valid_o), 64'd0);
        m0_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("rd_c5_m0ready", 64'(m0_ready_o), 64'd0);
        check_eq("rd_c5_grant", 64'(grant_o), 64'd0);

        // Stray acknowledge while idle is ignored
        s_ready_i = 1'b1; s_rdata_i = 32'h0000_FFFF;
        @(negedge clk_i);
        s_ready_i = 1'b0; s_rdata_i = '0;
        check_eq("idle_ack_ready", 64'({m0_ready_o, m1_ready_o}), 64'd0);
        check_eq("idle_ack_rdata", 64'(m0_rdata_o), 64'h1234_5678);
        @(negedge clk_i);
        check_eq("idle_ack_svalid", 64'(s_valid_o), 64'd0);

        // Tie after reset: sustained requests alternate m0, m1, m0, m1
        do_reset();
        m0_valid_i = 1'b1; m0_address_i = 16'h0100;
        m1_valid_i = 1'b1; m1_address_i = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_svalid($sformatf("tie%0d_svalid", i));
            check_eq($sformatf("tie%0d_grant", i), 64'(grant_o), 64'(exp_g));
            check_eq($sformatf("tie%0d_saddr", i), 64'(s_address_o),
                     (exp_g == 2'b01) ? 64'h0100 : 64'h0200);
            slave_ack(32'hA000_0000 + i);
            check_eq($sformatf("tie%0d_ready", i), 64'({m1_ready_o, m0_ready_o}), 64'(exp_g));
            check_eq($sformatf("tie%0d_rdata", i), 64'(m0_rdata_o), 64'(32'hA000_0000 + i));
        end
        m0_valid_i = 1'b0; m1_valid_i = 1'b0;
        @(negedge clk_i);

        // Write forwarding from m1, payload stable until acknowledge
        m1_valid_i = 1'b1; m1_address_i = 16'h0044;
        m1_wdata_i = 32'hCAFE_F00D; m1_wstrb_i = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq($sformatf("wr%0d_saddr", i), 64'(s_address_o), 64'h0044);
            check_eq($sformatf("wr%0d_swdata", i), 64'(s_wdata_o), 64'hCAFE_F00D);
            check_eq($sformatf("wr%0d_swstrb", i), 64'(s_wstrb_o), 64'h3);
            check_eq($sformatf("wr%0d_grant", i), 64'(grant_o), 64'd2);
        end
        slave_ack(32'h0);
        check_eq("wr_ready", 64'({m1_ready_o, m0_ready_o}), 64'b10);
        m1_valid_i = 1'b0; m1_wstrb_i = '0; m1_wdata_i = '0;
        @(negedge clk_i);

        // Late contender: m1 raises valid while m0 is in REQ
        m0_valid_i = 1'b1; m0_address_i = 16'h0020;
        @(negedge clk_i);
        check_eq("late_grant0", 64'(grant_o), 64'd1);
        m1_valid_i = 1'b1; m1_address_i = 16'h0030;
        @(negedge clk_i);
        check_eq("late_hold_saddr", 64'(s_address_o), 64'h0020);
        check_eq("late_hold_grant", 64'(grant_o), 64'd1);
        slave_ack(32'h0000_0011);
        check_eq("late_m0_ready", 64'({m1_ready_o, m0_ready_o}), 64'b01);
        m0_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("late_idle_svalid", 64'(s_valid_o), 64'd0);
        check_eq("late_idle_grant", 64'(grant_o), 64'd0);
        @(negedge clk_i);
        check_eq("late_m1_grant", 64'(grant_o), 64'd2);
        check_eq("late_m1_saddr", 64'(s_address_o), 64'h0030);
        slave_ack(32'h0000_0022);
        check_eq("late_m1_ready", 64'({m1_ready_o, m0_ready_o}), 64'b10);
        check_eq("late_m1_rdata", 64'(m1_rdata_o), 64'h22);
        m1_valid_i = 1'b0;
        @(negedge clk_i);

        // Reset asserted mid-REQ after an m0 grant
        m0_valid_i = 1'b1; m0_address_i = 16'h0050;
        @(negedge clk_i);
        check_eq("mrst_pre_svalid", 64'(s_valid_o), 64'd1);
        #2;
        arst_i = 1'b0;
        #1;
        check_eq("mrst_svalid", 64'(s_valid_o), 64'd0);
        check_eq("mrst_grant", 64'(grant_o), 64'd0);
        check_eq("mrst_saddr", 64'(s_address_o), 64'd0);
        check_eq("mrst_rdata", 64'(m0_rdata_o), 64'd0);
        m0_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("mrst_noready", 64'({m1_ready_o, m0_ready_o}), 64'd0);
        arst_i = 1'b1;
        m0_valid_i = 1'b1; m0_address_i = 16'h0060;
        m1_valid_i = 1'b1; m1_address_i = 16'h0070;
        @(negedge clk_i);
        check_eq("mrst_tie_grant", 64'(grant_o), 64'd1);
        slave_ack(32'h0000_0055);
        check_eq("mrst_tie_ready", 64'({m1_ready_o, m0_ready_o}), 64'b01);
        m0_valid_i = 1'b0;
        wait_svalid("mrst_m1_svalid");
        check_eq("mrst_m1_grant", 64'(grant_o), 64'd2);
        slave_ack(32'h0000_0066);
        m1_valid_i = 1'b0;
        @(negedge clk_i);

        // Slave never acknowledges m0; m1 queues behind it
        m0_valid_i = 1'b1; m0_address_i = 16'h0080;
        n_sv = 0;
        k = 0;
        @(negedge clk_i);
`ifdef ETHOC_ARB_TIMEOUT_EN
        while (m0_ready_o !== 1'b1 && k < 60) begin
            if (s_valid_o === 1'b1) n_sv++;
            if (k == 2) begin
                m1_valid_i = 1'b1; m1_address_i = 16'h0090;
            end
            @(negedge clk_i);
            k++;
        end
        check_eq("to_m0_ready", 64'(m0_ready_o), 64'd1);
        check_eq("to_pulse", 64'(timeout_o), 64'd1);
        check_eq("to_rdata", 64'(m0_rdata_o), 64'hDEAD_BEEF);
        check_eq("to_svalid", 64'(s_valid_o), 64'd0);
        check_eq("to_req_cycles", 64'(n_sv), 64'd16);
        m0_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("to_pulse_end", 64'(timeout_o), 64'd0);
`else
        m1_valid_i = 1'b1; m1_address_i = 16'h0090;
        repeat (30) @(negedge clk_i);
        check_eq("wait_svalid_held", 64'(s_valid_o), 64'd1);
        check_eq("wait_no_timeout", 64'(timeout_o), 64'd0);
        check_eq("wait_grant", 64'(grant_o), 64'd1);
        slave_ack(32'h0000_0044);
        check_eq("wait_m0_ready", 64'({m1_ready_o, m0_ready_o}), 64'b01);
        m0_valid_i = 1'b0;
`endif
        wait_svalid("after_m1_svalid");
        check_eq("after_m1_grant", 64'(grant_o), 64'd2);
        check_eq("after_m1_saddr", 64'(s_address_o), 64'h0090);
        slave_ack(32'h0000_0033);
        check_eq("after_m1_ready", 64'({m1_ready_o, m0_ready_o}), 64'b10);
        check_eq("after_m1_timeout", 64'(timeout_o), 64'd0);
        check_eq("after_m1_rdata", 64'(m1_rdata_o), 64'h33);
        m1_valid_i = 1'b0;
        @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_ethoc_arbiter.md
# iob_ethoc_arbiter

Two-requester IOb-bus arbiter that shares the single register/buffer-descriptor slave port of the `iob_ethoc` Ethernet MAC between the CPU (requester 0) and a descriptor/DMA engine (requester 1). It sits directly in front of `iob_ethoc`. It grants one transaction at a time with round-robin priority, registers the forwarded request, and returns the slave response only to the granted requester. An optional watchdog aborts transactions the MAC never acknowledges.

## Interface
- ADDR_W, 16, address width of all IOb ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT_CYC, 1024, watchdog limit in cycles. Used only with ETHOC_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- arst_i  in  1  asynchronous, active-low reset (asserted at 0).
- m0_valid_i, m1_valid_i  in  1  request valid; held with payload until own ready pulse.
- m0_address_i, m1_address_i  in  ADDR_W  request address.
- m0_wdata_i, m1_wdata_i  in  DATA_W  write data.
- m0_wstrb_i, m1_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read.
- m0_rdata_o, m1_rdata_o  out  DATA_W  both driven from one shared response register.
- m0_ready_o, m1_ready_o  out  1  one-cycle completion pulse to the granted requester only.
- s_valid_o  out  1  forwarded valid to iob_ethoc.
- s_address_o  out  ADDR_W  forwarded address.
- s_wdata_o  out  DATA_W  forwarded write data.
- s_wstrb_o  out  DATA_W/8  forwarded byte strobes.
- s_rdata_i  in  DATA_W  slave read data, valid when s_ready_i=1.
- s_ready_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - No valid: stay in IDLE.
  - Any valid: select a winner, latch its address/wdata/wstrb into the s_* registers, set grant_o, go to REQ.
- REQ:
  - s_valid_o=1; the payload is stable.
  - On s_ready_i=1: capture s_rdata_i into the rdata register, drop s_valid_o, go to RESP.
- RESP:
  - Pulse the winner's ready_o for exactly one cycle, clear grant_o, go to IDLE.
  - The requester drops valid after seeing ready. IDLE therefore never re-grants the same transaction.
- Round-robin: a 1-bit last_grant register, updated on every grant.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
- The rdata register is updated on every acknowledge, reads and writes alike. On writes its value is don't-care.
- A requester's valid rising while the other owns the bus waits; it is never dropped.

## Timing
- Reset values (arst_i=0): state IDLE, s_valid_o=0, s_address_o/s_wdata_o/s_wstrb_o=0, rdata=0, m*_ready_o=0, grant_o=00, timeout_o=0, last_grant=1 (so m0 wins the first tie), watchdog counter 0.
- Latency:
  - Valid seen in IDLE at cycle 0 gives s_valid_o=1 at cycle 1.
  - s_ready_i at cycle k (k≥1) gives m*_ready_o at cycle k+1.
  - Minimum is 2 cycles, valid to ready.
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP, so 3 cycles per transaction minimum. With both requesters continuously valid, grants alternate m0, m1, m0, …
- s_ready_i outside REQ is ignored.
- Reset asserted mid-transaction: the transaction is abandoned immediately, all outputs return to their reset values, and no ready is issued.

## Configuration
- ETHOC_ARB_TIMEOUT_EN defined:
  - A counter runs in REQ, cleared on entry.
  - If it reaches TIMEOUT_CYC−1 without s_ready_i, force s_valid_o=0, load rdata with ETHOC_ARB_TIMEOUT_RDATA (32'hDEAD_BEEF), pulse timeout_o, and go to RESP (normal ready pulse).
  - s_ready_i in the same cycle as expiry wins; this is a normal completion with no timeout.
- Not defined:
  - No counter logic; REQ waits indefinitely.
  - timeout_o is tied to 0.

## Structure
- Package iob_ethoc_arb_pkg holds:
  - the FSM state encoding (IDLE/REQ/RESP);
  - ETHOC_ARB_TIMEOUT_RDATA.
- Sub-module iob_ethoc_arb_rr: combinational round-robin selector. Inputs are the two valids and last_grant; output is the one-hot winner. It is instantiated once in the top.
- Registers use the codebase's iob_reg primitive or equivalent, with asynchronous active-low reset.

## Test plan
- Single read: m0 reads 0x0010, slave acks at cycle 3 with 0x1234_5678 → s_valid_o cycles 1–3, m0_ready_o pulse at cycle 4 with m0_rdata_o=0x1234_5678, m1_ready_o stays 0.
- Tie after reset: m0 and m1 valid at cycle 0 → m0 granted first, then m1; sustained requests alternate grant_o 01,10,01,10.
- Write forwarding: m1 writes 0xCAFE_F00D with wstrb=4'b0011 at 0x0044 while m0 idle → s_address_o/s_wdata_o/s_wstrb_o match exactly and are stable until s_ready_i.
- Late contender: m1 asserts valid while m0 is in REQ → m1 is not forwarded until after m0's ready pulse, then granted in the next IDLE.
- Reset mid-REQ: assert arst_i=0 while s_valid_o=1 → all outputs at reset values asynchronously, no ready pulse, and the next tie goes to m0.
- Timeout (macro on, TIMEOUT_CYC=16): slave never acks → timeout_o and m0_ready_o pulse with m0_rdata_o=0xDEAD_BEEF; the arbiter then serves a pending m1 request normally.
